// File: rtl/config_pkg.sv
// Core configuration types shared by the PMA lookup path.
// Holds the region rule tables, the per-request access and attribute types,
// and the address range helper used by every rule comparator.
package config_pkg;

  localparam int unsigned NrMaxRules = 8;

  typedef struct packed {
    logic                         NonIdemPotenceEn;
    int unsigned                  NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentLength;
    int unsigned                  NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  ExecuteRegionLength;
    int unsigned                  NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]  CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  CachedRegionLength;
    int unsigned                  NrSharedRegionRules;
    logic [NrMaxRules-1:0][63:0]  SharedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]  SharedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef enum logic [1:0] {
    PMA_LOAD  = 2'd0,
    PMA_STORE = 2'd1,
    PMA_FETCH = 2'd2,
    PMA_AMO   = 2'd3
  } pma_access_e;

  typedef struct packed {
    logic cacheable;
    logic executable;
    logic nonidempotent;
    logic shared;
  } pma_attr_t;

  // The upper bound is formed in 65 bits so a region ending exactly at 2^64
  // (or wrapping past it) still compares correctly.
  function automatic logic range_check(input logic [63:0] base,
                                       input logic [63:0] len,
                                       input logic [63:0] address);
    return (address >= base) && ({1'b0, address} < ({1'b0, base} + {1'b0, len}));
  endfunction

endpackage

// File: rtl/pma_rule_match.sv
// Combinational comparator bank for one attribute class.
// Produces one hit bit per rule slot; slots at or above the active rule
// count are masked off so unused table entries never contribute.
module pma_rule_match
  import config_pkg::*;
(
  input  logic [NrMaxRules-1:0][63:0] base_i,
  input  logic [NrMaxRules-1:0][63:0] len_i,
  input  logic [31:0]                 nr_rules_i,
  input  logic [63:0]                 addr_i,
  output logic [NrMaxRules-1:0]       hit_o
);

  for (genvar k = 0; k < NrMaxRules; k++) begin : g_rule
    assign hit_o[k] = (nr_rules_i > 32'(k)) && range_check(base_i[k], len_i[k], addr_i);
  end

endmodule

// File: rtl/pma_lookup_pipe.sv
// Two-stage physical-memory-attribute lookup.
// S1 captures the raw per-rule hit vectors for each class, S2 reduces them
// into the attribute bundle and the access-fault flag. A saturating counter
// tracks faulting responses taken by the consumer.
module pma_lookup_pipe
  import config_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           PLEN    = 56,
  parameter int unsigned           IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PLEN-1:0]    req_addr_i,
  input  pma_access_e        req_type_i,
  input  logic [IdWidth-1:0] req_id_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [IdWidth-1:0] rsp_id_o,
  output pma_attr_t          rsp_attr_o,
  output logic               rsp_fault_o,
  output logic [15:0]        fault_cnt_o
);

  logic [63:0]           addr64;
  logic [NrMaxRules-1:0] hit_c, hit_x, hit_n, hit_s;

  logic                  s1_valid_q, s1_valid_d;
  logic [IdWidth-1:0]    s1_id_q, s1_id_d;
  pma_access_e           s1_type_q, s1_type_d;
  logic [NrMaxRules-1:0] s1_hit_c_q, s1_hit_c_d;
  logic [NrMaxRules-1:0] s1_hit_x_q, s1_hit_x_d;
  logic [NrMaxRules-1:0] s1_hit_n_q, s1_hit_n_d;
  logic [NrMaxRules-1:0] s1_hit_s_q, s1_hit_s_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [IdWidth-1:0]    s2_id_q, s2_id_d;
  pma_attr_t             s2_attr_q, s2_attr_d;
  logic                  s2_fault_q, s2_fault_d;

  logic [15:0]           fault_cnt_q, fault_cnt_d;

  pma_attr_t             s1_attr;
  logic                  s1_fault;
  logic                  adv1, adv2;

  assign addr64 = 64'(req_addr_i);

  pma_rule_match u_match_cached (
    .base_i     (CVA6Cfg.CachedRegionAddrBase),
    .len_i      (CVA6Cfg.CachedRegionLength),
    .nr_rules_i (32'(CVA6Cfg.NrCachedRegionRules)),
    .addr_i     (addr64),
    .hit_o      (hit_c)
  );

  pma_rule_match u_match_exec (
    .base_i     (CVA6Cfg.ExecuteRegionAddrBase),
    .len_i      (CVA6Cfg.ExecuteRegionLength),
    .nr_rules_i (32'(CVA6Cfg.NrExecuteRegionRules)),
    .addr_i     (addr64),
    .hit_o      (hit_x)
  );

  pma_rule_match u_match_nonidem (
    .base_i     (CVA6Cfg.NonIdempotentAddrBase),
    .len_i      (CVA6Cfg.NonIdempotentLength),
    .nr_rules_i (32'(CVA6Cfg.NrNonIdempotentRules)),
    .addr_i     (addr64),
    .hit_o      (hit_n)
  );

  pma_rule_match u_match_shared (
    .base_i     (CVA6Cfg.SharedRegionAddrBase),
    .len_i      (CVA6Cfg.SharedRegionLength),
    .nr_rules_i (32'(CVA6Cfg.NrSharedRegionRules)),
    .addr_i     (addr64),
    .hit_o      (hit_s)
  );

  // A stage may move when the stage after it is empty or draining this cycle.
  assign adv2        = !s2_valid_q || rsp_ready_i;
  assign adv1        = !s1_valid_q || adv2;
  assign req_ready_o = adv1;

  // S1 next state: take a new request when S1 can advance; flush empties it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_type_d  = s1_type_q;
    s1_hit_c_d = s1_hit_c_q;
    s1_hit_x_d = s1_hit_x_q;
    s1_hit_n_d = s1_hit_n_q;
    s1_hit_s_d = s1_hit_s_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
    end else if (adv1) begin
      s1_valid_d = req_valid_i;
      if (req_valid_i) begin
        s1_id_d    = req_id_i;
        s1_type_d  = req_type_i;
        s1_hit_c_d = hit_c;
        s1_hit_x_d = hit_x;
        s1_hit_n_d = hit_n;
        s1_hit_s_d = hit_s;
      end
    end
  end

  // Reduce the S1 hit vectors into attributes and decide whether the access faults.
  always_comb begin
    s1_attr.cacheable     = |s1_hit_c_q;
    s1_attr.executable    = |s1_hit_x_q;
    s1_attr.nonidempotent = CVA6Cfg.NonIdemPotenceEn && (|s1_hit_n_q);
    s1_attr.shared        = |s1_hit_s_q;
    s1_fault = ((s1_type_q == PMA_FETCH) && !s1_attr.executable) ||
               ((s1_type_q == PMA_AMO)   && !s1_attr.cacheable);
  end

  // S2 next state: hold while the consumer stalls, otherwise take S1's result.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_attr_d  = s2_attr_q;
    s2_fault_d = s2_fault_q;
    if (flush_i) begin
      s2_valid_d = 1'b0;
    end else if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d    = s1_id_q;
        s2_attr_d  = s1_attr;
        s2_fault_d = s1_fault;
      end
    end
  end

  // Count faulting responses the consumer accepts, saturating at all-ones.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (rsp_valid_o && rsp_ready_i && rsp_fault_o && !flush_i && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_d = fault_cnt_q + 16'd1;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_type_q   <= PMA_LOAD;
      s1_hit_c_q  <= '0;
      s1_hit_x_q  <= '0;
      s1_hit_n_q  <= '0;
      s1_hit_s_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_attr_q   <= '0;
      s2_fault_q  <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_type_q   <= s1_type_d;
      s1_hit_c_q  <= s1_hit_c_d;
      s1_hit_x_q  <= s1_hit_x_d;
      s1_hit_n_q  <= s1_hit_n_d;
      s1_hit_s_q  <= s1_hit_s_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
      s2_attr_q   <= s2_attr_d;
      s2_fault_q  <= s2_fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign rsp_valid_o = s2_valid_q;
  assign rsp_id_o    = s2_id_q;
  assign rsp_attr_o  = s2_attr_q;
  assign rsp_fault_o = s2_fault_q;
  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_pma_lookup_pipe.sv
// Bench for pma_lookup_pipe: directed steps followed by a random phase, all
// checked against an in-order queue model of the two-cycle lookup.
module tb_pma_lookup_pipe;
  import config_pkg::*;

  localparam int unsigned PLEN    = 56;
  localparam int unsigned IdWidth = 4;

  function automatic cva6_cfg_t make_cfg();
    cva6_cfg_t c;
    c = '0;
    c.NonIdemPotenceEn         = 1'b0;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.CachedRegionAddrBase[1]  = 64'h0;             // beyond rule count, must be ignored
    c.CachedRegionLength[1]    = 64'h100_0000_0000;
    c.NrExecuteRegionRules     = 1;
    c.ExecuteRegionAddrBase[0] = 64'h1_0000;
    c.ExecuteRegionLength[0]   = 64'h1_0000;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h1000_0000;
    c.NrSharedRegionRules      = 0;
    c.SharedRegionAddrBase[0]  = 64'h0;             // class disabled, must be ignored
    c.SharedRegionLength[0]    = 64'h100_0000_0000;
    return c;
  endfunction

  localparam cva6_cfg_t Cfg = make_cfg();

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [PLEN-1:0]    req_addr_i;
  pma_access_e        req_type_i;
  logic [IdWidth-1:0] req_id_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [IdWidth-1:0] rsp_id_o;
  pma_attr_t          rsp_attr_o;
  logic               rsp_fault_o;
  logic [15:0]        fault_cnt_o;

  pma_lookup_pipe #(.CVA6Cfg(Cfg), .PLEN(PLEN), .IdWidth(IdWidth)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_type_i  (req_type_i),
    .req_id_i    (req_id_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_attr_o  (rsp_attr_o),
    .rsp_fault_o (rsp_fault_o),
    .fault_cnt_o (fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IdWidth-1:0] id;
    logic [3:0]         attr;
    logic               fault;
    int                 acc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] cnt;
  int          cyc_n;
  int          checks;
  int          errors;
  int          dut_rsp_cnt;
  int          ready_low_cnt;

  // Reference: a region holds a when a lies in [b, b+l), computed as an offset.
  function automatic logic in_rng(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
    return (a >= b) && ((a - b) < l);
  endfunction

  // Only the active rules matter: one cached window, one execute window,
  // non-idempotence globally disabled, no shared regions.
  function automatic logic [3:0] m_attr(input logic [63:0] a);
    logic c, x;
    c = in_rng(a, 64'h8000_0000, 64'h4000_0000);
    x = in_rng(a, 64'h1_0000, 64'h1_0000);
    return {c, x, 1'b0, 1'b0};
  endfunction

  function automatic logic m_fault(input logic [3:0] attr, input pma_access_e t);
    return ((t == PMA_FETCH) && !attr[2]) || ((t == PMA_AMO) && !attr[3]);
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] a;
    case ($urandom_range(0, 12))
      0:  a = 64'h8000_0000;
      1:  a = 64'hBFFF_FFFF;
      2:  a = 64'hC000_0000;
      3:  a = 64'h7FFF_FFFF;
      4:  a = 64'h1_0000;
      5:  a = 64'h1_FFFF;
      6:  a = 64'h2_0000;
      7:  a = 64'hFFFF;
      8:  a = 64'h0FFF_FFFF;
      9:  a = 64'h500;
      10: a = {32'h0, $urandom()};
      11: a = {8'h0, $urandom_range(0, 32'h00FF_FFFF), $urandom()} & 64'h00FF_FFFF_FFFF_FFFF;
      default: a = 64'h8000_0000 + 64'($urandom_range(0, 32'h3FFF_FFFF));
    endcase
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cyc(input logic v, input logic [63:0] a, input pma_access_e t,
                     input logic [IdWidth-1:0] id, input logic rr, input logic fl);
    logic exp_ready, exp_vis;
    exp_t e;
    @(negedge clk_i);
    req_valid_i = v;
    req_addr_i  = a[PLEN-1:0];
    req_type_i  = t;
    req_id_i    = id;
    rsp_ready_i = rr;
    flush_i     = fl;
    #1;
    exp_ready = (q.size() < 2) || rr;
    exp_vis   = (q.size() > 0) && (cyc_n >= q[0].acc + 2);
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_vis));
    if (exp_vis) begin
      chk("rsp_id", 64'(rsp_id_o), 64'(q[0].id));
      chk("rsp_attr", 64'(rsp_attr_o), 64'(q[0].attr));
      chk("rsp_fault", 64'(rsp_fault_o), 64'(q[0].fault));
    end
    chk("fault_cnt", 64'(fault_cnt_o), 64'(cnt));
    if (!req_ready_o) ready_low_cnt++;
    if (rsp_valid_o && rr && !fl) dut_rsp_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (exp_vis && rr) begin
        if (q[0].fault && (cnt != 16'hFFFF)) cnt++;
        void'(q.pop_front());
      end
      if (v && exp_ready) begin
        e.id    = id;
        e.attr  = m_attr(a & 64'h00FF_FFFF_FFFF_FFFF);
        e.fault = m_fault(e.attr, t);
        e.acc   = cyc_n;
        q.push_back(e);
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 64'h0, PMA_LOAD, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int n0, sent;
    logic rr;
    logic acc;
    checks = 0; errors = 0; cnt = '0; cyc_n = 0; dut_rsp_cnt = 0; ready_low_cnt = 0;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    req_type_i = PMA_LOAD; req_id_i = '0; rsp_ready_i = 1'b0;

    #3;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id_o), 64'h0);
    chk("rst_rsp_attr", 64'(rsp_attr_o), 64'h0);
    chk("rst_rsp_fault", 64'(rsp_fault_o), 64'h0);
    chk("rst_fault_cnt", 64'(fault_cnt_o), 64'h0);
    @(negedge clk_i); @(negedge clk_i);
    #2 rst_i = 1'b0;
    idle(1);

    // Cached window and its edges, one at a time so latency is visible.
    cyc(1'b1, 64'h8000_0000, PMA_LOAD, 4'd1, 1'b1, 1'b0); idle(3);
    cyc(1'b1, 64'hBFFF_FFFF, PMA_LOAD, 4'd2, 1'b1, 1'b0);
    cyc(1'b1, 64'hC000_0000, PMA_LOAD, 4'd3, 1'b1, 1'b0); idle(3);

    // Faults: fetch outside the execute window, AMO to uncached memory.
    cyc(1'b1, 64'h2_0000, PMA_FETCH, 4'd4, 1'b1, 1'b0); idle(3);
    cyc(1'b1, 64'h1_FFFF, PMA_FETCH, 4'd5, 1'b1, 1'b0); idle(3);
    cyc(1'b1, 64'h500, PMA_AMO, 4'd6, 1'b1, 1'b0); idle(3);
    cyc(1'b1, 64'h8000_0040, PMA_AMO, 4'd7, 1'b1, 1'b0);
    cyc(1'b1, 64'h100, PMA_STORE, 4'd8, 1'b1, 1'b0); idle(3);

    // Stream of 8 tagged requests with a 3-cycle consumer stall.
    n0 = dut_rsp_cnt; sent = 0; ready_low_cnt = 0;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      rr  = !(c >= 3 && c < 6);
      acc = (q.size() < 2) || rr;
      cyc(1'b1, pick_addr(), pma_access_e'($urandom_range(0, 3)), 4'(sent), rr, 1'b0);
      if (acc) sent++;
    end
    idle(4);
    chk("stream_count", 64'(dut_rsp_cnt - n0), 64'd8);
    chk("stream_backpressure", 64'(ready_low_cnt > 0), 64'd1);

    // Flush with two lookups in flight and a third offered in the same cycle.
    n0 = dut_rsp_cnt;
    cyc(1'b1, 64'h2_0000, PMA_FETCH, 4'd9, 1'b1, 1'b0);
    cyc(1'b1, 64'h500, PMA_AMO, 4'd10, 1'b1, 1'b0);
    cyc(1'b1, 64'h8000_0000, PMA_LOAD, 4'd11, 1'b1, 1'b1);
    idle(3);
    chk("flush_no_rsp", 64'(dut_rsp_cnt - n0), 64'd0);
    cyc(1'b1, 64'h8000_0000, PMA_LOAD, 4'd12, 1'b1, 1'b0); idle(3);

    // Non-idempotent rule hit with the feature disabled.
    cyc(1'b1, 64'h100, PMA_LOAD, 4'd13, 1'b1, 1'b0); idle(3);

    // Saturation from 16'hFFFE.
    @(negedge clk_i);
    #2 force dut.fault_cnt_q = 16'hFFFE;
    @(posedge clk_i);
    #1 release dut.fault_cnt_q;
    cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) cyc(1'b1, 64'h2_0000, PMA_FETCH, 4'(k), 1'b1, 1'b0);
    idle(3);
    chk("sat_cnt", 64'(fault_cnt_o), 64'hFFFF);

    // Random traffic with stalls and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), pick_addr(), pma_access_e'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 31) == 0));
    end
    idle(4);

    // Asynchronous reset while a response is waiting.
    cyc(1'b1, 64'h8000_0000, PMA_FETCH, 4'd5, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, PMA_LOAD, '0, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, PMA_LOAD, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("arst_rsp_id", 64'(rsp_id_o), 64'h0);
    chk("arst_rsp_attr", 64'(rsp_attr_o), 64'h0);
    chk("arst_rsp_fault", 64'(rsp_fault_o), 64'h0);
    chk("arst_fault_cnt", 64'(fault_cnt_o), 64'h0);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    q.delete();
    cnt = '0;
    idle(2);
    cyc(1'b1, 64'h1_0000, PMA_FETCH, 4'd3, 1'b1, 1'b0); idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
